// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for the dual-clock FIFO (read clock domain).
// Issues FIFO reads against the registered empty flag, absorbs the FIFO's
// one-cycle read latency and delivers beats on a valid/ready stream through
// a 2-entry buffer with registered m_valid/m_data.
//
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the beat_cnt port,
// a CW-bit wrapping count of accepted output beats.
// ---------------------------------------------------------------------------

// Property checker for the credit scheme of fifo_rd_stream.
module fifo_rd_stream_chk #(
    parameter int CW = 16
) (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic [1:0] occ
);

    // A capture into a full buffer that is not draining would lose data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (occ == 2'd2) && !pop));

    // Buffered beats plus the read in flight never exceed the buffer depth.
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, occ} + {2'b00, push}) <= 3'd2));

    // The beat counter needs at least one bit.
    a_cw_legal: assert property (@(posedge clk) (CW >= 1));

endmodule

module fifo_rd_stream #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          r_clk,
    input  logic          r_rst_n,
    input  logic          en,
    input  logic          fifo_empty,
    output logic          fifo_r_en,
    input  logic [DW-1:0] fifo_r_data,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [1:0]    buf_lvl
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CW-1:0] beat_cnt
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          run_r;        // goes high one edge after reset release
    logic          inflight_r;   // a FIFO read was accepted last cycle
    logic [1:0]    occ_r;        // buffer occupancy, 0..2
    logic          head_r;       // entry presented on m_data
    logic          tail_r;       // entry written by the next capture
    logic [DW-1:0] mem_r [2];    // buffer storage
    logic          m_valid_r;
    logic [DW-1:0] m_data_r;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic          pop_s;
    logic          push_s;
    logic [2:0]    credit_s;
    logic          rd_en_s;
    logic [1:0]    occ_nxt_s;
    logic          head_nxt_s;
    logic          tail_nxt_s;
    logic          m_valid_nxt_s;
    logic [DW-1:0] m_data_nxt_s;

    // Read issue: only request a beat if it is guaranteed a buffer slot,
    // counting the read already in flight and the pop happening this cycle.
    always_comb begin
        pop_s    = m_valid_r && m_ready;
        push_s   = inflight_r;
        credit_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (run_r && en && !fifo_empty && (credit_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Occupancy and pointer update from the push/pop pair.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + 2'd1;
            2'b01:   occ_nxt_s = occ_r - 2'd1;
            2'b11:   occ_nxt_s = occ_r;
            2'b00:   occ_nxt_s = occ_r;
            default: occ_nxt_s = occ_r;
        endcase
        head_nxt_s    = head_r ^ pop_s;
        tail_nxt_s    = tail_r ^ push_s;
        m_valid_nxt_s = (occ_nxt_s != 2'd0);
    end

    // Next output word is the post-update head entry; a capture landing on
    // that entry this cycle must bypass storage so m_data is never stale.
    always_comb begin
        if (push_s && (tail_r == head_nxt_s)) begin
            m_data_nxt_s = fifo_r_data;
        end else begin
            m_data_nxt_s = mem_r[head_nxt_s];
        end
    end

    // Start-up gate and read-latency tracking.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            run_r      <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            run_r      <= 1'b1;
            inflight_r <= rd_en_s;
        end
    end

    // Buffer pointers, occupancy and the registered output stage.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            occ_r     <= 2'd0;
            head_r    <= 1'b0;
            tail_r    <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= {DW{1'b0}};
        end else begin
            occ_r     <= occ_nxt_s;
            head_r    <= head_nxt_s;
            tail_r    <= tail_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            m_data_r  <= m_data_nxt_s;
        end
    end

    // Buffer storage: capture FIFO read data at the tail.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            mem_r[0] <= {DW{1'b0}};
            mem_r[1] <= {DW{1'b0}};
        end else if (push_s) begin
            mem_r[tail_r] <= fifo_r_data;
        end else begin
            mem_r[0] <= mem_r[0];
            mem_r[1] <= mem_r[1];
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CW-1:0] beat_cnt_r;

    // Accepted-beat counter, wraps naturally at 2^CW.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            beat_cnt_r <= {CW{1'b0}};
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
`endif

    assign fifo_r_en = rd_en_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign buf_lvl   = occ_r;

    fifo_rd_stream_chk #(
        .CW (CW)
    ) u_chk (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .occ   (occ_r)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
// Scoreboard bench: stimulus loads a behavioural FIFO and pushes the expected
// beats into exp_q; a monitor on the falling edge checks every presented beat
// against the head of exp_q and pops it on acceptance.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 8;
`ifdef FIFO_RD_STREAM_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          r_clk = 1'b0;
    logic          r_rst_n;
    logic          en;
    logic          fifo_empty = 1'b1;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_r_data = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [1:0]    buf_lvl;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CW-1:0] beat_cnt;
`endif

    int tests    = 0;
    int fails    = 0;
    int rd_count = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    fifo_rd_stream #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .r_clk       (r_clk),
        .r_rst_n     (r_rst_n),
        .en          (en),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_r_data (fifo_r_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .buf_lvl     (buf_lvl)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .beat_cnt    (beat_cnt)
`endif
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: registered empty flag, data one cycle after a read.
    always @(posedge r_clk) begin
        if (fifo_r_en) begin
            check("read_not_empty", {31'd0, (fifo_q.size() != 0)}, 32'd1);
            if (fifo_q.size() != 0) begin
                fifo_r_data <= fifo_q.pop_front();
                rd_count++;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge r_clk) begin
        if (r_rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", m_data, $time);
            end else begin
                check("beat_data", {24'd0, m_data}, {24'd0, exp_q[0]});
                if (m_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge r_clk);
    endtask

    task automatic load(input int base, input int n, input bit expect_it);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            if (expect_it) begin
                exp_q.push_back(DW'(base + i));
            end
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || m_valid) && (n < bound)) begin
            smp();
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        int lat;
        int run_len;
        int rd0;
        int maxl;

        // Reset with a non-empty FIFO and enable high.
        r_rst_n = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        load(8'hA5, 1, 1'b1);
        repeat (3) @(posedge r_clk);
        smp();
        check("rst_fifo_r_en", fifo_r_en, 32'd0);
        check("rst_m_valid", m_valid, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_buf_lvl", buf_lvl, 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("rst_beat_cnt", beat_cnt, 32'd0);
`endif
        r_rst_n = 1'b1;
        #1;
        check("rel_no_read_before_edge1", fifo_r_en, 32'd0);
        smp();
        check("first_read_edge2", fifo_r_en, 32'd1);

        // Single beat: valid two cycles after the read, one-cycle pulse.
        smp();
        check("single_not_yet_valid", m_valid, 32'd0);
        smp();
        check("single_valid", m_valid, 32'd1);
        check("single_lvl1", buf_lvl, 32'd1);
        smp();
        check("single_pulse_end", m_valid, 32'd0);
        check("single_lvl0", buf_lvl, 32'd0);

        // Streaming 16 beats, also measuring empty-fall to valid latency.
        step();
        load(8'h00, 16, 1'b1);
        n = 0;
        while (fifo_empty && (n < 10)) begin
            smp();
            n++;
        end
        check("lat_empty_seen", fifo_empty, 32'd0);
        lat = 0;
        while (!m_valid && (lat < 10)) begin
            smp();
            lat++;
        end
        check("lat_empty_to_valid", lat, 32'd2);
        run_len = 0;
        while (m_valid && (run_len < 40)) begin
            run_len++;
            smp();
        end
        check("stream_run_len", run_len, 32'd16);
        check("stream_all_seen", exp_q.size(), 32'd0);

        // Backpressure: stall 5 cycles mid-stream.
        step();
        load(8'h10, 8, 1'b1);
        n = 0;
        while (!m_valid && (n < 10)) begin
            smp();
            n++;
        end
        step();
        m_ready = 1'b0;
        maxl = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (int'(buf_lvl) > maxl) begin
                maxl = int'(buf_lvl);
            end
            check("bp_hold_valid", m_valid, 32'd1);
        end
        check("bp_peak_lvl", maxl, 32'd2);
        check("bp_r_en_low", fifo_r_en, 32'd0);
        step();
        m_ready = 1'b1;
        smp();
        check("bp_resume_same_cycle", fifo_r_en, 32'd1);
        drain("bp_no_loss", 40);

        // en drop right after the first read is issued.
        step();
        load(8'h20, 1, 1'b1);
        load(8'h21, 3, 1'b0);
        n = 0;
        while (!fifo_r_en && (n < 10)) begin
            smp();
            n++;
        end
        check("en_read_seen", fifo_r_en, 32'd1);
        rd0 = rd_count;
        step();
        en = 1'b0;
        repeat (8) smp();
        check("en_reads_after_drop", rd_count - rd0, 32'd1);
        check("en_beat_delivered", exp_q.size(), 32'd0);
        check("en_fifo_left", fifo_q.size(), 32'd3);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h23);
        step();
        en = 1'b1;
        drain("en_resume", 30);

        // Reset mid-stream with a full buffer.
        step();
        m_ready = 1'b0;
        load(8'h40, 6, 1'b1);
        repeat (6) smp();
        check("mr_full", buf_lvl, 32'd2);
        step();
        r_rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check("mr_m_valid", m_valid, 32'd0);
        check("mr_buf_lvl", buf_lvl, 32'd0);
        check("mr_m_data", m_data, 32'd0);
        check("mr_fifo_r_en", fifo_r_en, 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("mr_beat_cnt", beat_cnt, 32'd0);
`endif
        m_ready = 1'b1;
        repeat (2) step();
        r_rst_n = 1'b1;
        repeat (6) smp();
        check("mr_no_stale_beat", m_valid, 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // 17 pops on a 4-bit counter wraps to 1.
        step();
        load(8'h50, 17, 1'b1);
        drain("cnt_drain", 60);
        check("cnt_wrap", beat_cnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
